// File: rtl/mem_stage_param.sv
// Memory (M) stage with a registered write-back (W) bundle.
// Holds a DEPTH x 8 little-endian data memory. Stores finish in one cycle.
// Loads finish READ_LAT cycles after they are accepted. While a multi-cycle
// load is outstanding, StallM holds the upstream M inputs.
// Out-of-range or illegal-size accesses finish as a single-cycle error.

module mem_stage_param #(
  parameter int DATA_W   = 19,
  parameter int DEPTH    = 256,
  parameter int REG_W    = 5,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic              ResultSrcM,
  input  logic              SignedM,
  input  logic [1:0]        SizeM,
  input  logic [REG_W-1:0]  RDM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALUResultM,
  output logic              StallM,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic              ErrW,
  output logic [REG_W-1:0]  RDW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ResultW
);

  // Bytes in a full word access.
  localparam int NB  = (DATA_W + 7) / 8;
  // Width of a memory index.
  localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Width for the range check. It is wide enough that addr + size cannot
  // wrap, and wide enough to hold DEPTH.
  localparam int EW  = (DATA_W + 2 > 33) ? DATA_W + 2 : 33;
  // Width of the latency counter. It covers READ_LAT - 1 up to 3.
  localparam int CW  = 3;
  // Width of the raw read bus. It must reach bit 15 for half sign extension.
  localparam int RW  = (NB * 8 > 16) ? NB * 8 : 16;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              resultsrc;
    logic              err;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
  } w_t;

  logic [7:0]        mem_q [DEPTH];
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  w_t                w_q, w_d;
  w_t                pend_q;
  w_t                op_w;

  logic              is_load, is_store, is_mem;
  int                nbytes;
  int                nbits;
  logic [EW-1:0]     end_addr;
  logic              err;
  logic              accept, multi, done, mem_we;
  logic [AIW-1:0]    idx [NB];
  logic [RW-1:0]     raw;
  logic              ext_bit;
  logic [DATA_W-1:0] ld_data;
  logic [NB*8-1:0]   wdata_ext;
  logic              unused_raw;

  // Decode the op, check its range, and decide acceptance and stall.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    is_load  = MemReadM;
    is_store = MemWriteM & ~MemReadM;   // read wins when both are set
    is_mem   = is_load | is_store;
    nbytes   = NB;
    nbits    = DATA_W;
    case (SizeM)
      2'b00:   begin nbytes = 1; nbits = 8;  end
      2'b01:   begin nbytes = 2; nbits = 16; end
      default: begin nbytes = NB; nbits = DATA_W; end
    endcase
    end_addr = EW'(ALUResultM) + EW'(nbytes) - EW'(1);
    err      = is_mem & ((SizeM == 2'b11) | (end_addr >= EW'(DEPTH)));
    accept   = reset & ValidM & (state_q == IDLE);
    multi    = accept & is_load & ~err & (READ_LAT > 1);
    done     = (state_q == BUSY) & (cnt_q == CW'(READ_LAT - 1));
    mem_we   = accept & is_store & ~err;
    // Stall is released in the completion cycle. It is also forced low while
    // reset is asserted.
    StallM   = reset & (multi | ((state_q == BUSY) & ~done));
  end

  // Compute the byte indices, gather the read bytes and format the load data.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NB; i++) begin
      idx[i]          = AIW'(ALUResultM + DATA_W'(i));
      raw[8*i +: 8]   = mem_q[idx[i]];
    end
    ext_bit = SignedM & ((SizeM == 2'b00) ? raw[7] :
                         (SizeM == 2'b01) ? raw[15] : 1'b0);
    for (int b = 0; b < DATA_W; b++) begin
      ld_data[b] = (b < nbits) ? raw[b] : ext_bit;
    end
    wdata_ext = (NB * 8)'(WriteDataM);
  end

  // Bits of the last raw byte that lie beyond DATA_W are unused.
  assign unused_raw = ^raw;

  // Build the W bundle for the current op, and select what W loads next.
  always_comb begin
    op_w.valid     = 1'b1;
    op_w.regwrite  = RegWriteM & ~err;
    op_w.resultsrc = ResultSrcM;
    op_w.err       = err;
    op_w.rd        = RDM;
    op_w.rdata     = (is_load & ~err) ? ld_data : '0;
    op_w.alu       = ALUResultM;

    w_d = '0;                           // bubble unless an op completes
    if (done) begin
      w_d = pend_q;
    end else if (accept & ~multi) begin
      w_d = op_w;
    end
  end

  // Write the byte array. Only the bytes covered by the access size are written.
  // NOTE: the memory array has no reset; its contents survive reset and need no reset tree.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we && (i < nbytes)) begin
        mem_q[idx[i]] <= wdata_ext[8*i +: 8];
      end
    end
  end

  // Run the load-latency FSM and hold the W stage registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      pend_q  <= '0;
    end else begin
      w_q <= w_d;
      case (state_q)
        IDLE: begin
          if (multi) begin
            state_q <= BUSY;
            cnt_q   <= CW'(1);
            pend_q  <= op_w;
          end
        end
        BUSY: begin
          if (done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ValidW     = w_q.valid;
  assign RegWriteW  = w_q.regwrite;
  assign ResultSrcW = w_q.resultsrc;
  assign ErrW       = w_q.err;
  assign RDW        = w_q.rd;
  assign ReadDataW  = w_q.rdata;
  assign ALUResultW = w_q.alu;
  assign ResultW    = w_q.resultsrc ? w_q.rdata : w_q.alu;

endmodule
